mean_threshold: RTL and testbench
=================================

// Module: mean_threshold
// PURPOSE
//  Adaptive-threshold stage between BGR2GRAY and BINARIZATION.
//  After gray_done, reads every gray pixel once from a read port of BMP_DUAL_PORT_RAM and sums them.
//  Integer-divides the sum by the pixel count and presents the 8-bit mean as threshold to BINARIZATION.
//  Replaces the fixed threshold constant.
// PARAMETERS
//  BYTE_WIDTH   8       pixel byte width
//  ADDR_WIDTH   20      RAM address width
//  HEADER_SIZE  54      BMP header bytes; first pixel at this address
//  IMG_WIDTH    512     pixels per row
//  IMG_HEIGHT   512     rows
//  SUM_WIDTH    26      accumulator width; must be >= BYTE_WIDTH + clog2(IMG_WIDTH*IMG_HEIGHT)
//  THR_LO       16      lower clamp bound (clamp feature only)
//  THR_HI       240     upper clamp bound (clamp feature only)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  in_valid   in   1           system enable, level
//  gray_done  in   1           BGR2GRAY finished; level, stays high
//  RAM_ren    out  1           RAM read enable
//  RAM_addr   out  ADDR_WIDTH  RAM read byte address
//  RAM_out    in   BYTE_WIDTH  RAM read data; valid 1 cycle after RAM_ren
//  threshold  out  BYTE_WIDTH  computed threshold; stable once done=1
//  done       out  1           result valid; level, held until rst
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; RAM_ren=0, RAM_addr=0, threshold=0, done=0; sum and counters cleared.
//  Reset mid-operation aborts immediately; nothing is resumed.
//  FSM:
//   IDLE:   in_valid && gray_done -> READ. Either input low -> stay in IDLE.
//   READ:   RAM_ren=1 every cycle, one pixel per cycle.
//           Address = B byte of each pixel: HEADER_SIZE + row*ROW_BYTES + 3*col.
//           ROW_BYTES = 3*IMG_WIDTH rounded up to a multiple of 4; pad bytes are never read.
//           Address advances with col/row counters, not a multiply.
//           After pixel N-1 is issued (N = IMG_WIDTH*IMG_HEIGHT) -> DRAIN.
//   DRAIN:  1 cycle, RAM_ren=0; last RAM_out is accumulated -> DIVIDE.
//   DIVIDE: restoring divider, 1 quotient bit/cycle, SUM_WIDTH cycles.
//           quotient = floor(sum/N); always <= 255 -> DONE.
//   DONE:   threshold registered, done=1, RAM_ren=0; holds until rst.
//  Accumulate: sum += RAM_out on each cycle after an issued read (1-cycle RAM latency).
//   Zero-extended, unsigned; no overflow when SUM_WIDTH is legal.
//  Latency from the IDLE->READ transition edge to done=1: N + 1 + SUM_WIDTH + 1 cycles.
//  In READ/DRAIN/DIVIDE, in_valid and gray_done are ignored (a deassert does not abort).
//  RAM_wen is never driven by this block; no write port is used.
//  RAM_addr holds its last value whenever RAM_ren=0.
// CONFIGURATION
//  MEAN_THRESHOLD_CLAMP_EN defined:
//   threshold = min(max(quotient, THR_LO), THR_HI), applied at the DIVIDE->DONE edge.
//   Latency unchanged.
//  Not defined: threshold = quotient; THR_LO and THR_HI are unused.
// TESTING
//  1) 4x4 image, all pixels 100, N=16
//     -> 16 reads at 54,57,60,63,66,...; threshold=100.
//     -> done rises exactly 16+1+SUM_WIDTH+1 cycles after the start edge.
//  2) 4x4 image, first 8 pixels 0, last 8 pixels 255 -> sum=2040, threshold=127.
//  3) IMG_WIDTH=2, IMG_HEIGHT=2 (ROW_BYTES=8)
//     -> addresses 54,57,62,65 only; pad bytes 60,61,68,69 never read.
//  4) 512x512, all pixels 255 -> sum=66846720 with no overflow; threshold=255.
//  5) rst pulsed for 1 cycle mid-READ -> all outputs 0 immediately.
//     -> rerun with in_valid && gray_done=1 gives threshold identical to an uninterrupted run.
//  6) MEAN_THRESHOLD_CLAMP_EN defined:
//     -> all-0 image gives threshold=16; all-255 image gives threshold=240.
//     -> all-100 image gives threshold=100.

Source files
------------

// File: rtl/mean_threshold.sv
// Sums every gray pixel (B byte) once, divides by the pixel count, presents the 8-bit mean; MEAN_THRESHOLD_CLAMP_EN clamps it to [THR_LO, THR_HI].
// Latency start->done = N reads + 1 drain + 1 divider load + SUM_WIDTH quotient bits; no backpressure, RAM answers in 1 cycle.
module mean_threshold #(
    parameter int BYTE_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 20,
    parameter int HEADER_SIZE = 54,
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512,
    parameter int SUM_WIDTH   = 26,
    parameter int THR_LO      = 16,
    parameter int THR_HI      = 240
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  gray_done,
    output logic                  RAM_ren,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    input  logic [BYTE_WIDTH-1:0] RAM_out,
    output logic [BYTE_WIDTH-1:0] threshold,
    output logic                  done
);
    localparam int N         = IMG_WIDTH * IMG_HEIGHT;
    localparam int ROW_BYTES = ((3 * IMG_WIDTH + 3) / 4) * 4;
    localparam int PW        = $clog2(N + 1);
    localparam int CW        = $clog2(IMG_WIDTH + 1);
    localparam int DW        = $clog2(SUM_WIDTH + 1);

    localparam logic [SUM_WIDTH-1:0]  DIV   = SUM_WIDTH'(N);
    localparam logic [BYTE_WIDTH-1:0] LO_B  = BYTE_WIDTH'(THR_LO);
    localparam logic [BYTE_WIDTH-1:0] HI_B  = BYTE_WIDTH'(THR_HI);
`ifdef MEAN_THRESHOLD_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_DIVIDE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [CW-1:0]         col_q, col_d;
    logic [PW-1:0]         pix_q, pix_d;
    logic                  ren_q;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d;
    logic [SUM_WIDTH-1:0]  rem_q, rem_d;
    logic [SUM_WIDTH-1:0]  quo_q, quo_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic [BYTE_WIDTH-1:0] thr_q, thr_d;
    logic                  done_q, done_d;

    // One restoring-divider step: {rem, quo} shifts left, quotient bit enters at the bottom.
    logic [SUM_WIDTH:0]    rem_sh;
    logic                  ge;
    logic [SUM_WIDTH-1:0]  rem_sub;
    logic [SUM_WIDTH-1:0]  quo_shift;
    logic [BYTE_WIDTH-1:0] q_fin;
    logic [BYTE_WIDTH-1:0] thr_fin;

    assign rem_sh    = {rem_q, quo_q[SUM_WIDTH-1]};
    assign ge        = (rem_sh >= {1'b0, DIV});
    assign rem_sub   = rem_sh[SUM_WIDTH-1:0] - DIV;
    assign quo_shift = {quo_q[SUM_WIDTH-2:0], ge};
    assign q_fin     = quo_shift[BYTE_WIDTH-1:0];

    always_comb begin
        thr_fin = q_fin;
        if (CLAMP_EN) begin
            if (q_fin < LO_B)      thr_fin = LO_B;
            else if (q_fin > HI_B) thr_fin = HI_B;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        pix_d      = pix_q;
        sum_d      = sum_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dcnt_d     = dcnt_q;
        thr_d      = thr_q;
        done_d     = done_q;

        if (ren_q) sum_d = sum_q + SUM_WIDTH'(RAM_out);

        case (state_q)
            S_IDLE: begin
                if (in_valid && gray_done) begin
                    state_d    = S_READ;
                    addr_d     = ADDR_WIDTH'(HEADER_SIZE);
                    row_base_d = ADDR_WIDTH'(HEADER_SIZE);
                    col_d      = '0;
                    pix_d      = '0;
                    sum_d      = '0;
                end
            end
            S_READ: begin
                // The last issued address is kept so RAM_addr holds while idle.
                if (pix_q == PW'(N - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    pix_d = pix_q + 1'b1;
                    if (col_q == CW'(IMG_WIDTH - 1)) begin
                        col_d      = '0;
                        row_base_d = row_base_q + ADDR_WIDTH'(ROW_BYTES);
                        addr_d     = row_base_q + ADDR_WIDTH'(ROW_BYTES);
                    end else begin
                        col_d  = col_q + 1'b1;
                        addr_d = addr_q + ADDR_WIDTH'(3);
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DIVIDE;
                dcnt_d  = '0;
            end
            S_DIVIDE: begin
                if (dcnt_q == '0) begin
                    rem_d  = '0;
                    quo_d  = sum_q;
                    dcnt_d = DW'(1);
                end else begin
                    quo_d = quo_shift;
                    rem_d = ge ? rem_sub : rem_sh[SUM_WIDTH-1:0];
                    if (dcnt_q == DW'(SUM_WIDTH)) begin
                        state_d = S_DONE;
                        thr_d   = thr_fin;
                        done_d  = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            row_base_q <= '0;
            col_q      <= '0;
            pix_q      <= '0;
            ren_q      <= 1'b0;
            sum_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dcnt_q     <= '0;
            thr_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            pix_q      <= pix_d;
            ren_q      <= RAM_ren;
            sum_q      <= sum_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dcnt_q     <= dcnt_d;
            thr_q      <= thr_d;
            done_q     <= done_d;
        end
    end

    assign RAM_ren   = (state_q == S_READ);
    assign RAM_addr  = addr_q;
    assign threshold = thr_q;
    assign done      = done_q;
endmodule

// File: tb/tb_mean_threshold.sv
// Bench for mean_threshold: a 4x4 instance (minimal SUM_WIDTH) and a 2x2 instance (row padding).
module tb_mean_threshold;
    localparam int SW_A = 12;
    localparam int SW_B = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, iv_a, gd_a, ren_a, done_a;
    logic [19:0] addr_a;
    logic [7:0]  ramo_a, thr_a;
    logic        rst_b, iv_b, gd_b, ren_b, done_b;
    logic [19:0] addr_b;
    logic [7:0]  ramo_b, thr_b;

    logic [7:0] mem_a [0:127];
    logic [7:0] mem_b [0:127];

    mean_threshold #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .SUM_WIDTH(SW_A)) u_dut_a (
        .clk(clk), .rst(rst_a), .in_valid(iv_a), .gray_done(gd_a),
        .RAM_ren(ren_a), .RAM_addr(addr_a), .RAM_out(ramo_a),
        .threshold(thr_a), .done(done_a)
    );

    mean_threshold #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .SUM_WIDTH(SW_B)) u_dut_b (
        .clk(clk), .rst(rst_b), .in_valid(iv_b), .gray_done(gd_b),
        .RAM_ren(ren_b), .RAM_addr(addr_b), .RAM_out(ramo_b),
        .threshold(thr_b), .done(done_b)
    );

    always @(posedge clk) if (ren_a) ramo_a <= mem_a[addr_a[6:0]];
    always @(posedge clk) if (ren_b) ramo_b <= mem_b[addr_b[6:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_addr_a[$];
    int exp_addr_b[$];
    int exp_thr_a[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_thr(input int q);
`ifdef MEAN_THRESHOLD_CLAMP_EN
        if (q < 16)  return 16;
        if (q > 240) return 240;
`endif
        return q;
    endfunction

    // Every issued read is matched against the address scoreboard.
    always @(negedge clk) begin
        if (ren_a === 1'b1) begin
            if (exp_addr_a.size() == 0) check_val("addr_a_unexpected", addr_a, 32'hFFFF_FFFF);
            else                        check_val("addr_a", addr_a, exp_addr_a.pop_front());
        end
        if (ren_b === 1'b1) begin
            if (exp_addr_b.size() == 0) check_val("addr_b_unexpected", addr_b, 32'hFFFF_FFFF);
            else                        check_val("addr_b", addr_b, exp_addr_b.pop_front());
        end
    end

    function automatic int pix_val(input int pat, input int p);
        case (pat)
            0: return 100;
            1: return (p < 8) ? 0 : 255;
            2: return 255;
            3: return 0;
            default: return (p * 37 + 11) % 256;
        endcase
    endfunction

    task automatic reset_check_a(input string tag);
        rst_a = 1'b1;
        #1;
        check_val(tag, {ren_a, addr_a, thr_a, done_a}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    // abort_at > 0: reset the block that many cycles after the start edge.
    task automatic run_a(input int pat, input int abort_at);
        int sum;
        int k;
        bit seen;
        int a;
        sum = 0;
        for (int i = 0; i < 128; i++) mem_a[i] = 8'($urandom_range(0, 255));
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a = 54 + r * 12 + c * 3;
                mem_a[a] = 8'(pix_val(pat, r * 4 + c));
                sum += pix_val(pat, r * 4 + c);
                exp_addr_a.push_back(a);
            end
        end
        exp_thr_a.push_back(exp_thr(sum / 16));
        @(negedge clk);
        iv_a = 1'b1;
        gd_a = 1'b1;
        @(posedge clk);
        k = 0;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 3) begin
                iv_a = 1'b0;
                gd_a = 1'b0;
            end
            if (abort_at != 0 && k == abort_at) begin
                reset_check_a("abort_outputs_a");
                exp_addr_a.delete();
                void'(exp_thr_a.pop_front());
                return;
            end
            seen = done_a;
        end
        if (!seen) begin
            check_val("done_timeout_a", 32'd0, 32'd1);
        end else begin
            check_val("latency_a", k, 16 + SW_A + 2);
            check_val("thr_a", thr_a, exp_thr_a.pop_front());
            check_val("addrs_left_a", exp_addr_a.size(), 32'd0);
            repeat (3) @(negedge clk);
            check_val("done_hold_a", {done_a, ren_a}, 32'd2);
        end
        @(negedge clk);
        reset_check_a("post_reset_a");
    endtask

    initial begin
        int k;
        int sum;
        int vals[4];
        int addrs[4];
        rst_a = 1'b1; iv_a = 1'b0; gd_a = 1'b0;
        rst_b = 1'b1; iv_b = 1'b0; gd_b = 1'b0;
        #12;
        check_val("reset_a", {ren_a, addr_a, thr_a, done_a}, 32'd0);
        check_val("reset_b", {ren_b, addr_b, thr_b, done_b}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Only one start condition present: must stay idle.
        iv_a = 1'b1;
        repeat (5) @(negedge clk);
        check_val("idle_iv_only", {ren_a, done_a}, 32'd0);
        iv_a = 1'b0;
        gd_a = 1'b1;
        repeat (5) @(negedge clk);
        check_val("idle_gd_only", {ren_a, done_a}, 32'd0);
        gd_a = 1'b0;

        run_a(0, 0);
        run_a(1, 0);
        run_a(2, 0);
        run_a(3, 0);
        run_a(4, 7);
        run_a(4, 0);

        // 2x2 image: row stride 8, pad bytes 60,61,68,69 must never be read.
        for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom_range(0, 255));
        vals  = '{10, 20, 30, 41};
        addrs = '{54, 57, 62, 65};
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            mem_b[addrs[i]] = 8'(vals[i]);
            sum += vals[i];
            exp_addr_b.push_back(addrs[i]);
        end
        @(negedge clk);
        iv_b = 1'b1;
        gd_b = 1'b1;
        @(posedge clk);
        k = 0;
        while (k < 100 && done_b !== 1'b1) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_val("latency_b", k, 4 + SW_B + 2);
        check_val("thr_b", thr_b, exp_thr(sum / 4));
        check_val("addrs_left_b", exp_addr_b.size(), 32'd0);
        check_val("addr_hold_b", addr_b, 32'd65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
